branch_predictor_btb: RTL and testbench
=======================================

Name: branch_predictor_btb

Overview:
Dynamic branch predictor and resolver for the 5-stage MIPS pipeline. It replaces the static ID-stage branch decision.
- In IF, a direct-mapped branch target buffer (BTB) with 2-bit saturating counters predicts taken/target.
- The prediction is carried to ID in an internal pipeline register.
- In ID, beq/bne/j are resolved against the prediction. The block issues redirect/flush on mispredict and updates the table.

Parameters:
ADDR_W, 32, PC/target width in bits.
INDEX_W, 4, log2 of BTB depth (DEPTH = 2**INDEX_W = 16 entries).
CNT_INIT, 2'b01, counter value loaded at reset (weakly not-taken).

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
pcF  input  ADDR_W  fetch PC
predTakenF  output  1  IF prediction: take predTargetF next cycle
predTargetF  output  ADDR_W  predicted target
stallD  input  1  hold ID register (hazard unit)
flushD  input  1  load bubble into ID register (hazard unit)
opCodeD  input  6  ID instruction opcode
compResultD  input  1  ID register-equality compare
branchTargetD  input  ADDR_W  computed branch target
pcPlus4D  input  ADDR_W  PC+4 of ID instruction
PCSrcS  output  1  redirect fetch to redirectPC
redirectPC  output  ADDR_W  corrected fetch address
FlushS  output  1  flush IF/ID on mispredict
jumpS  output  1  unconditional jump in ID

Behaviour:
- Index = pcF[INDEX_W+1:2]; tag = pcF[ADDR_W-1:INDEX_W+2]. Each entry holds valid, tag, target, cnt[1:0].
- IF lookup is combinational. hitF = valid && tag match. predTakenF = hitF && cnt[1]. predTargetF = entry target (0 when no hit).
- ID register holds {validD, pcD, predTakenD, predTargetD}.
  - rst or flushD: cleared to a bubble (flushD wins over stallD).
  - stallD: hold.
  - Otherwise: load from IF with validD=1.
- Resolution is combinational in ID and applies only when validD=1.
  - beq (4): actual = compResultD. bne (5): actual = ~compResultD.
  - Branch, actual=1, and (!predTakenD or predTargetD != branchTargetD): PCSrcS=1, FlushS=1, redirectPC=branchTargetD.
  - Branch, actual=0, predTakenD=1: PCSrcS=1, FlushS=1, redirectPC=pcPlus4D.
  - Branch matching prediction: PCSrcS=0, FlushS=0.
  - j (2): jumpS=1. If predTakenD=1, also PCSrcS=1, FlushS=1, redirectPC=pcPlus4D; the jump path then overrides fetch.
  - Other opcode with predTakenD=1 (alias): PCSrcS=1, FlushS=1, redirectPC=pcPlus4D.
  - When no redirect is issued, PCSrcS/FlushS=0 and redirectPC=0.
- Table update on the clock edge when validD && !stallD && !rst, at the index of pcD.
  - Branch hit: cnt saturating ±1 (taken: 3 stays 3; not-taken: 0 stays 0); target <= branchTargetD when taken.
  - Branch miss, taken: allocate valid=1, tag, target, cnt=2'b10.
  - Branch miss, not taken: no write.
  - Non-branch with predTakenD=1: invalidate entry if tag matches.
  - j: no table write.
- A same-index IF lookup and ID update in one cycle: the lookup sees the pre-update value (no bypass).
- Reset: all valid=0, all cnt=CNT_INIT, ID register bubbled. All outputs are 0 during and after reset until the first fetch hits. Reset asserted mid-operation discards the in-flight ID prediction and issues no redirect.
- Latency: prediction 0 cycles (IF), resolution 0 cycles (ID), table visible 1 cycle after update edge.

Optional Feature:
BP_STATS_EN:
- Defined: adds output ports branchCnt[31:0] and mispredCnt[31:0]. Both are reset to 0 and saturate at 32'hFFFFFFFF.
  - branchCnt increments per resolved beq/bne (update condition).
  - mispredCnt increments per cycle with FlushS=1 under the update condition.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then pcF=0x40 -> predTakenF=0, predTargetF=0; all outputs 0.
- beq at pcD=0x40, compResultD=1, branchTargetD=0x80, no prior entry -> PCSrcS=1, FlushS=1, redirectPC=0x80. Next fetch of 0x40 -> predTakenF=1, predTargetF=0x80.
- Same beq taken 3 more times, then compResultD=0 -> 4th taken cycle has no flush. Not-taken cycle: FlushS=1, redirectPC=pcPlus4D=0x44. cnt drops 3→2, so the prediction stays taken.
- bne at 0x100, compResultD=1, no entry -> no redirect, no allocation; refetch 0x100 -> predTakenF=0.
- Alias: entry for 0x40 (index 0), fetch add at 0x440 with a matching tag setup (predTakenD=1, opCodeD=0) -> FlushS=1, redirectPC=0x444, entry invalidated.
- stallD=1 for 2 cycles with a taken beq in ID -> no table write until stallD drops. flushD=1 with stallD=1 -> bubble, no redirect. With BP_STATS_EN: counts match the issued branches and flushes.

Source files
------------

// File: rtl/branch_predictor_btb.sv
// Dynamic branch predictor / resolver for the 5-stage MIPS pipeline.
// IF: direct-mapped BTB lookup with 2-bit saturating counters.
// ID: resolves beq/bne/j against the carried prediction, redirects on
// mispredict and trains the table.
// Optional build macro BP_STATS_EN adds branchCnt/mispredCnt statistics ports.
module branch_predictor_btb #(
    parameter int         ADDR_W   = 32,
    parameter int         INDEX_W  = 4,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pcF,
    output logic              predTakenF,
    output logic [ADDR_W-1:0] predTargetF,
    input  logic              stallD,
    input  logic              flushD,
    input  logic [5:0]        opCodeD,
    input  logic              compResultD,
    input  logic [ADDR_W-1:0] branchTargetD,
    input  logic [ADDR_W-1:0] pcPlus4D,
    output logic              PCSrcS,
    output logic [ADDR_W-1:0] redirectPC,
    output logic              FlushS,
    output logic              jumpS
`ifdef BP_STATS_EN
    ,
    output logic [31:0]       branchCnt,
    output logic [31:0]       mispredCnt
`endif
);

    localparam int DEPTH = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    localparam logic [5:0] OP_J   = 6'd2;
    localparam logic [5:0] OP_BEQ = 6'd4;
    localparam logic [5:0] OP_BNE = 6'd5;

    // Move a 2-bit counter one step toward taken (up=1) or not-taken, clamped.
    function automatic logic [1:0] cnt_step(input logic [1:0] c, input logic up);
        logic [1:0] r;
        r = c;
        if (up) begin
            if (c != 2'b11) r = c + 2'b01;
        end else begin
            if (c != 2'b00) r = c - 2'b01;
        end
        return r;
    endfunction

    // Increment a 32-bit event counter, sticking at all ones.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // ------------------------------------------------------------------
    // BTB storage: valid/cnt are control state (reset), tag/target are data.
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] valid_q;
    logic [1:0]       cnt_q    [DEPTH];
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [ADDR_W-1:0] target_q [DEPTH];

    // ------------------------------------------------------------------
    // IF stage: combinational lookup
    // ------------------------------------------------------------------
    logic [INDEX_W-1:0] idxF;
    logic [TAG_W-1:0]   tagF;
    logic               hitF;
    logic               predTakenRawF;
    logic [ADDR_W-1:0]  predTargetRawF;

    assign idxF           = pcF[INDEX_W+1:2];
    assign tagF           = pcF[ADDR_W-1:INDEX_W+2];
    assign hitF           = valid_q[idxF] && (tag_q[idxF] == tagF);
    assign predTakenRawF  = hitF && cnt_q[idxF][1];
    assign predTargetRawF = hitF ? target_q[idxF] : '0;

    // Outputs are forced quiet while reset is held, even if stale entries remain.
    assign predTakenF  = predTakenRawF && !rst;
    assign predTargetF = rst ? '0 : predTargetRawF;

    // ------------------------------------------------------------------
    // IF/ID boundary: prediction carried into ID
    // ------------------------------------------------------------------
    logic              validD_q,      validD_d;
    logic              predTakenD_q,  predTakenD_d;
    logic [ADDR_W-1:0] pcD_q,         pcD_d;
    logic [ADDR_W-1:0] predTargetD_q, predTargetD_d;

    // Next-state for the ID prediction register: flush beats stall, stall holds.
    always_comb begin
        validD_d      = validD_q;
        predTakenD_d  = predTakenD_q;
        pcD_d         = pcD_q;
        predTargetD_d = predTargetD_q;
        if (flushD) begin
            validD_d     = 1'b0;
            predTakenD_d = 1'b0;
        end else if (!stallD) begin
            validD_d      = 1'b1;
            predTakenD_d  = predTakenRawF;
            pcD_d         = pcF;
            predTargetD_d = predTargetRawF;
        end
    end

    // ID control bits: reset to a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            validD_q     <= 1'b0;
            predTakenD_q <= 1'b0;
        end else begin
            validD_q     <= validD_d;
            predTakenD_q <= predTakenD_d;
        end
    end

    // ID data fields: only meaningful when validD_q is set.
    always_ff @(posedge clk) begin
        pcD_q         <= pcD_d;
        predTargetD_q <= predTargetD_d;
    end

    // ------------------------------------------------------------------
    // ID stage: resolution and table training
    // ------------------------------------------------------------------
    logic               isBranchD;
    logic               actualD;
    logic               activeD;
    logic               updD;
    logic [INDEX_W-1:0] idxD;
    logic [TAG_W-1:0]   tagD;
    logic               hitD;

    assign isBranchD = (opCodeD == OP_BEQ) || (opCodeD == OP_BNE);
    assign actualD   = (opCodeD == OP_BEQ) ? compResultD : ~compResultD;
    assign activeD   = validD_q && !rst;
    assign updD      = validD_q && !stallD && !rst;
    assign idxD      = pcD_q[INDEX_W+1:2];
    assign tagD      = pcD_q[ADDR_W-1:INDEX_W+2];
    assign hitD      = valid_q[idxD] && (tag_q[idxD] == tagD);

    // Compare actual outcome with the carried prediction and pick a redirect.
    always_comb begin
        PCSrcS     = 1'b0;
        FlushS     = 1'b0;
        jumpS      = 1'b0;
        redirectPC = '0;
        if (activeD) begin
            if (isBranchD) begin
                if (actualD && (!predTakenD_q || (predTargetD_q != branchTargetD))) begin
                    PCSrcS     = 1'b1;
                    FlushS     = 1'b1;
                    redirectPC = branchTargetD;
                end else if (!actualD && predTakenD_q) begin
                    PCSrcS     = 1'b1;
                    FlushS     = 1'b1;
                    redirectPC = pcPlus4D;
                end
            end else if (opCodeD == OP_J) begin
                jumpS = 1'b1;
                if (predTakenD_q) begin
                    PCSrcS     = 1'b1;
                    FlushS     = 1'b1;
                    redirectPC = pcPlus4D;
                end
            end else if (predTakenD_q) begin
                // Non-branch aliased onto a taken entry: fall back to sequential fetch.
                PCSrcS     = 1'b1;
                FlushS     = 1'b1;
                redirectPC = pcPlus4D;
            end
        end
    end

    logic               entWr_d;
    logic               entValid_d;
    logic [1:0]         entCnt_d;
    logic [TAG_W-1:0]   entTag_d;
    logic [ADDR_W-1:0]  entTarget_d;

    // Build the single-entry write for the ID instruction's slot.
    always_comb begin
        entWr_d     = 1'b0;
        entValid_d  = valid_q[idxD];
        entCnt_d    = cnt_q[idxD];
        entTag_d    = tag_q[idxD];
        entTarget_d = target_q[idxD];
        if (updD) begin
            if (isBranchD) begin
                if (hitD) begin
                    entWr_d  = 1'b1;
                    entCnt_d = cnt_step(cnt_q[idxD], actualD);
                    if (actualD) entTarget_d = branchTargetD;
                end else if (actualD) begin
                    entWr_d     = 1'b1;
                    entValid_d  = 1'b1;
                    entCnt_d    = 2'b10;
                    entTag_d    = tagD;
                    entTarget_d = branchTargetD;
                end
            end else if ((opCodeD != OP_J) && predTakenD_q && hitD) begin
                entWr_d    = 1'b1;
                entValid_d = 1'b0;
            end
        end
    end

    // BTB control state: cleared on reset, trained from ID.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_INIT;
        end else if (entWr_d) begin
            valid_q[idxD] <= entValid_d;
            cnt_q[idxD]   <= entCnt_d;
        end
    end

    // BTB tag/target data written alongside the control update.
    always_ff @(posedge clk) begin
        if (entWr_d) begin
            tag_q[idxD]    <= entTag_d;
            target_q[idxD] <= entTarget_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] branchCnt_q, branchCnt_d;
    logic [31:0] mispredCnt_q, mispredCnt_d;

    // Statistics next-state: resolved branches and mispredict flushes.
    always_comb begin
        branchCnt_d  = branchCnt_q;
        mispredCnt_d = mispredCnt_q;
        if (updD && isBranchD) branchCnt_d  = sat_inc32(branchCnt_q);
        if (updD && FlushS)    mispredCnt_d = sat_inc32(mispredCnt_q);
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            branchCnt_q  <= '0;
            mispredCnt_q <= '0;
        end else begin
            branchCnt_q  <= branchCnt_d;
            mispredCnt_q <= mispredCnt_d;
        end
    end

    assign branchCnt  = branchCnt_q;
    assign mispredCnt = mispredCnt_q;
`endif

    // Word-offset bits never select a BTB entry.
    logic unused_bits;
    assign unused_bits = ^{pcF[1:0], pcD_q[1:0]};

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Scoreboard bench for branch_predictor_btb: a stimulus process pushes the
// reference model's expected outputs, a monitor pops and compares on negedge.
module tb_branch_predictor_btb;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcF;
    logic        predTakenF;
    logic [31:0] predTargetF;
    logic        stallD;
    logic        flushD;
    logic [5:0]  opCodeD;
    logic        compResultD;
    logic [31:0] branchTargetD;
    logic [31:0] pcPlus4D;
    logic        PCSrcS;
    logic [31:0] redirectPC;
    logic        FlushS;
    logic        jumpS;
`ifdef BP_STATS_EN
    logic [31:0] branchCnt;
    logic [31:0] mispredCnt;
`endif

    always #5 clk = ~clk;

    branch_predictor_btb dut (
        .clk          (clk),
        .rst          (rst),
        .pcF          (pcF),
        .predTakenF   (predTakenF),
        .predTargetF  (predTargetF),
        .stallD       (stallD),
        .flushD       (flushD),
        .opCodeD      (opCodeD),
        .compResultD  (compResultD),
        .branchTargetD(branchTargetD),
        .pcPlus4D     (pcPlus4D),
        .PCSrcS       (PCSrcS),
        .redirectPC   (redirectPC),
        .FlushS       (FlushS),
        .jumpS        (jumpS)
`ifdef BP_STATS_EN
        ,
        .branchCnt    (branchCnt),
        .mispredCnt   (mispredCnt)
`endif
    );

    typedef struct {
        logic        ptk;
        logic [31:0] ptgt;
        logic        pcs;
        logic [31:0] rpc;
        logic        fls;
        logic        jmp;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: a 16-entry table indexed by word address modulo 16.
    bit          m_v   [16];
    logic [31:0] m_tag [16];
    logic [31:0] m_tgt [16];
    int          m_cnt [16];
    bit          m_vD;
    bit          m_ptD;
    logic [31:0] m_pcD;
    logic [31:0] m_ptgD;
    logic [31:0] m_bc;
    logic [31:0] m_mc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are combinational, so one expectation per cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("predTakenF",  {31'd0, predTakenF}, {31'd0, e.ptk});
            chk("predTargetF", predTargetF,          e.ptgt);
            chk("PCSrcS",      {31'd0, PCSrcS},      {31'd0, e.pcs});
            chk("redirectPC",  redirectPC,           e.rpc);
            chk("FlushS",      {31'd0, FlushS},      {31'd0, e.fls});
            chk("jumpS",       {31'd0, jumpS},       {31'd0, e.jmp});
`ifdef BP_STATS_EN
            chk("branchCnt",   branchCnt,            e.bc);
            chk("mispredCnt",  mispredCnt,           e.mc);
`endif
        end
    end

    // One cycle: drive inputs, predict outputs, push them, then advance the model.
    task automatic step(input logic [31:0] pc, input logic [5:0] op, input bit cmp,
                        input logic [31:0] bt, input bit st, input bit fl, input bit r);
        int          fi, di;
        logic [31:0] ft, dt, pc4;
        bit          fhit, fpt, dhit, isbr, act, upd;
        logic [31:0] fptg;
        exp_t        e;

        pc4 = m_pcD + 32'd4;
        rst = r; pcF = pc; opCodeD = op; compResultD = cmp;
        branchTargetD = bt; stallD = st; flushD = fl; pcPlus4D = pc4;

        fi   = int'((pc / 4) % 16);
        ft   = pc / 64;
        fhit = m_v[fi] && (m_tag[fi] == ft);
        fpt  = fhit && (m_cnt[fi] >= 2);
        fptg = fhit ? m_tgt[fi] : 32'd0;

        isbr = (op == 6'd4) || (op == 6'd5);
        act  = (op == 6'd4) ? cmp : !cmp;

        e.ptk = r ? 1'b0 : fpt;
        e.ptgt = r ? 32'd0 : fptg;
        e.pcs = 1'b0; e.fls = 1'b0; e.jmp = 1'b0; e.rpc = 32'd0;
        e.bc = m_bc; e.mc = m_mc;
        if (!r && m_vD) begin
            if (isbr) begin
                if (act && (!m_ptD || m_ptgD != bt)) begin
                    e.pcs = 1'b1; e.fls = 1'b1; e.rpc = bt;
                end else if (!act && m_ptD) begin
                    e.pcs = 1'b1; e.fls = 1'b1; e.rpc = pc4;
                end
            end else begin
                if (op == 6'd2) e.jmp = 1'b1;
                if (m_ptD) begin
                    e.pcs = 1'b1; e.fls = 1'b1; e.rpc = pc4;
                end
            end
        end
        exp_q.push_back(e);

        @(posedge clk);

        upd  = m_vD && !st && !r;
        di   = int'((m_pcD / 4) % 16);
        dt   = m_pcD / 64;
        dhit = m_v[di] && (m_tag[di] == dt);
        if (r) begin
            for (int i = 0; i < 16; i++) begin
                m_v[i] = 1'b0;
                m_cnt[i] = 1;
            end
            m_bc = 32'd0;
            m_mc = 32'd0;
        end else if (upd) begin
            if (isbr) begin
                if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 32'd1;
                if (dhit) begin
                    if (act) begin
                        m_cnt[di] = (m_cnt[di] < 3) ? m_cnt[di] + 1 : 3;
                        m_tgt[di] = bt;
                    end else begin
                        m_cnt[di] = (m_cnt[di] > 0) ? m_cnt[di] - 1 : 0;
                    end
                end else if (act) begin
                    m_v[di] = 1'b1; m_tag[di] = dt; m_tgt[di] = bt; m_cnt[di] = 2;
                end
            end else if (op != 6'd2 && m_ptD && dhit) begin
                m_v[di] = 1'b0;
            end
            if (e.fls && m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 32'd1;
        end

        if (r || fl) begin
            m_vD = 1'b0; m_ptD = 1'b0;
        end else if (!st) begin
            m_vD = 1'b1; m_pcD = pc; m_ptD = fpt; m_ptgD = fptg;
        end
        #1;
    endtask

    logic [31:0] pc_pool [8];
    logic [31:0] bt_pool [4];
    logic [5:0]  op_pool [5];

    initial begin
        pc_pool = '{32'h40, 32'h44, 32'h80, 32'h100, 32'h440, 32'h1040, 32'h84, 32'hC0};
        bt_pool = '{32'h80, 32'hC0, 32'h200, 32'h44};
        op_pool = '{6'd4, 6'd5, 6'd2, 6'd0, 6'h23};
        for (int i = 0; i < 16; i++) begin
            m_v[i] = 1'b0; m_tag[i] = 32'd0; m_tgt[i] = 32'd0; m_cnt[i] = 1;
        end
        m_vD = 1'b0; m_ptD = 1'b0; m_pcD = 32'd0; m_ptgD = 32'd0;
        m_bc = 32'd0; m_mc = 32'd0;
        rst = 1'b1; pcF = 32'h40; stallD = 1'b0; flushD = 1'b0; opCodeD = 6'd0;
        compResultD = 1'b0; branchTargetD = 32'd0; pcPlus4D = 32'd0;

        @(posedge clk); #1;
        // Reset and first lookup
        step(32'h40, 6'd0, 0, 32'h0,  0, 0, 1);
        step(32'h40, 6'd0, 0, 32'h0,  0, 0, 1);
        step(32'h40, 6'd0, 0, 32'h0,  0, 0, 0);
        // beq taken with no entry, then refetch hits
        step(32'h48, 6'd4, 1, 32'h80, 0, 0, 0);
        step(32'h40, 6'd0, 0, 32'h0,  0, 0, 0);
        // Three more taken, then not-taken; prediction stays taken
        step(32'h40, 6'd4, 1, 32'h80, 0, 0, 0);
        step(32'h40, 6'd4, 1, 32'h80, 0, 0, 0);
        step(32'h40, 6'd4, 1, 32'h80, 0, 0, 0);
        step(32'h44, 6'd4, 0, 32'h80, 0, 0, 0);
        step(32'h40, 6'd0, 0, 32'h0,  0, 0, 0);
        // bne not taken with no entry: no allocation
        step(32'h100, 6'd0, 0, 32'h0,  0, 0, 0);
        step(32'h104, 6'd5, 1, 32'h200, 0, 0, 0);
        step(32'h100, 6'd0, 0, 32'h0,  0, 0, 0);
        // Alias: allocate 0x440, then present it in ID as a non-branch
        step(32'h440, 6'd0, 0, 32'h0,   0, 0, 0);
        step(32'h444, 6'd4, 1, 32'h300, 0, 0, 0);
        step(32'h440, 6'd0, 0, 32'h0,   0, 0, 0);
        step(32'h444, 6'd0, 0, 32'h0,   0, 0, 0);
        step(32'h440, 6'd0, 0, 32'h0,   0, 0, 0);
        // Stall with a taken beq in ID
        step(32'h40, 6'd0, 0, 32'h0,  0, 0, 0);
        step(32'h48, 6'd4, 1, 32'h80, 1, 0, 0);
        step(32'h48, 6'd4, 1, 32'h80, 1, 0, 0);
        step(32'h48, 6'd4, 1, 32'h80, 0, 0, 0);
        step(32'h40, 6'd0, 0, 32'h0,  0, 0, 0);
        // Flush wins over stall
        step(32'h40, 6'd0, 0, 32'h0,  0, 0, 0);
        step(32'h44, 6'd4, 1, 32'h80, 1, 1, 0);
        step(32'h44, 6'd4, 1, 32'h80, 0, 0, 0);
        // Reset in the middle of an ID resolution
        step(32'h40, 6'd0, 0, 32'h0,  0, 0, 0);
        step(32'h44, 6'd4, 0, 32'h0,  0, 0, 1);
        step(32'h40, 6'd4, 1, 32'h80, 0, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            step(pc_pool[$urandom_range(0, 7)],
                 op_pool[$urandom_range(0, 4)],
                 1'($urandom_range(0, 1)),
                 bt_pool[$urandom_range(0, 3)],
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 99) == 0));
        end

        // Drain the scoreboard with a bounded wait
        for (int w = 0; w < 4 && exp_q.size() > 0; w++) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
